// File: rtl/train_sequencer.sv
// train_sequencer: initiator of the layer fp/bp pulse protocol. Launches one step, captures
// the output-layer activations, derives the saturated error vector and winning class.
`ifndef NUM_WIDTH
`define NUM_WIDTH 16
`endif

module train_sequencer #(
   parameter int N_OUT   = 4,
   parameter int TIMEOUT = 255,
   parameter int IDX_W   = 2,
   parameter int W       = `NUM_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               train,
   input  logic [N_OUT*W-1:0] target,
   output logic               fp_o,
   input  logic               fp_ret,
   input  logic [N_OUT*W-1:0] a_in,
   output logic [N_OUT*W-1:0] e_o,
   output logic               bp_o,
   input  logic               bp_ret,
   output logic [N_OUT*W-1:0] result,
   output logic [IDX_W-1:0]   class_o,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FWD   = 3'd1,
      FWAIT = 3'd2,
      ERR   = 3'd3,
      BWD   = 3'd4,
      BWAIT = 3'd5,
      DONE  = 3'd6
   } state_t;

   state_t               state_q, state_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic                 train_q, train_d;
   logic [N_OUT*W-1:0]   tgt_q, tgt_d;
   logic [N_OUT*W-1:0]   result_q, result_d;
   logic [N_OUT*W-1:0]   e_q, e_d;
   logic [IDX_W-1:0]     class_q, class_d;
   logic                 fp_q, fp_d;
   logic                 bp_q, bp_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;

   // W+1-bit difference; overflow shows as disagreement between the two top bits
   function automatic logic [W-1:0] sat_sub(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0] diff;
      diff = {a[W-1], a} - {b[W-1], b};
      if (diff[W] != diff[W-1]) begin
         sat_sub = diff[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end else begin
         sat_sub = diff[W-1:0];
      end
   endfunction

   function automatic logic [IDX_W-1:0] argmax(input logic [N_OUT*W-1:0] v);
      logic signed [W-1:0] best;
      logic [IDX_W-1:0]    idx;
      best = $signed(v[W-1:0]);
      idx  = '0;
      for (int i = 1; i < N_OUT; i++) begin
         if ($signed(v[i*W +: W]) > best) begin
            best = $signed(v[i*W +: W]);
            idx  = IDX_W'(i);
         end else begin
            idx  = idx;
         end
      end
      return idx;
   endfunction

   // Next-state, datapath updates and next values of the registered outputs
   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      train_d  = train_q;
      tgt_d    = tgt_q;
      result_d = result_q;
      e_d      = e_q;
      class_d  = class_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               train_d = train;
               err_d   = 1'b0;
               state_d = FWD;
            end else begin
               state_d = IDLE;
            end
         end
         FWD: begin
            timer_d = '0;
            state_d = FWAIT;
         end
         FWAIT: begin
            if (fp_ret) begin
               result_d = a_in;
               tgt_d    = target;
               state_d  = ERR;
            end else if (timer_q == TLAST) begin
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         ERR: begin
            for (int i = 0; i < N_OUT; i++) begin
               e_d[i*W +: W] = sat_sub(result_q[i*W +: W], tgt_q[i*W +: W]);
            end
            class_d = argmax(result_q);
            state_d = train_q ? BWD : DONE;
         end
         BWD: begin
            timer_d = '0;
            state_d = BWAIT;
         end
         BWAIT: begin
            if (bp_ret) begin
               state_d = DONE;
            end else if (timer_q == TLAST) begin
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      fp_d   = (state_d == FWD);
      bp_d   = (state_d == BWD);
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   // State register and all held values; reset cuts any pulse in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         timer_q  <= '0;
         train_q  <= 1'b0;
         tgt_q    <= '0;
         result_q <= '0;
         e_q      <= '0;
         class_q  <= '0;
         fp_q     <= 1'b0;
         bp_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         train_q  <= train_d;
         tgt_q    <= tgt_d;
         result_q <= result_d;
         e_q      <= e_d;
         class_q  <= class_d;
         fp_q     <= fp_d;
         bp_q     <= bp_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign fp_o    = fp_q;
   assign bp_o    = bp_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign err     = err_q;
   assign e_o     = e_q;
   assign result  = result_q;
   assign class_o = class_q;

endmodule

// File: tb/tb_train_sequencer.sv
// Directed bench for train_sequencer: fwd-only, training, timeout, return on the timeout
// cycle, and asynchronous reset in BWAIT, with hand-computed expected values.
module tb_train_sequencer;
   localparam int W       = 16;
   localparam int N_OUT   = 4;
   localparam int IDX_W   = 2;
   localparam int TIMEOUT = 8;
   localparam int VW      = N_OUT * W;

   logic             clk    = 1'b0;
   logic             rst_n  = 1'b1;
   logic             start  = 1'b0;
   logic             train  = 1'b0;
   logic             fp_ret = 1'b0;
   logic             bp_ret = 1'b0;
   logic [VW-1:0]    target = '0;
   logic [VW-1:0]    a_in   = '0;
   logic             fp_o, bp_o, busy, done, err;
   logic [VW-1:0]    e_o, result;
   logic [IDX_W-1:0] class_o;

   int n_vec    = 0;
   int n_miscmp = 0;
   int fp_cnt   = 0;
   int bp_cnt   = 0;
   int done_cnt = 0;
   int both_cnt = 0;

   always #5 clk = ~clk;

   train_sequencer #(.N_OUT(N_OUT), .TIMEOUT(TIMEOUT), .IDX_W(IDX_W), .W(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .train(train), .target(target),
      .fp_o(fp_o), .fp_ret(fp_ret), .a_in(a_in), .e_o(e_o), .bp_o(bp_o), .bp_ret(bp_ret),
      .result(result), .class_o(class_o), .busy(busy), .done(done), .err(err)
   );

   // pulse counters sampled mid-cycle
   always @(negedge clk) begin
      if (fp_o) fp_cnt <= fp_cnt + 1;
      if (bp_o) bp_cnt <= bp_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (fp_o && bp_o) both_cnt <= both_cnt + 1;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miscmp++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [VW-1:0] lanes(input logic [W-1:0] l0, input logic [W-1:0] l1,
                                           input logic [W-1:0] l2, input logic [W-1:0] l3);
      return {l3, l2, l1, l0};
   endfunction

   initial begin
      int c;
      int fp0, bp0, d0;

      // reset state
      #2 rst_n = 1'b0;
      #10;
      check("rst_busy",   64'(busy),    64'd0);
      check("rst_done",   64'(done),    64'd0);
      check("rst_err",    64'(err),     64'd0);
      check("rst_fp",     64'(fp_o),    64'd0);
      check("rst_bp",     64'(bp_o),    64'd0);
      check("rst_e",      64'(e_o),     64'd0);
      check("rst_result", 64'(result),  64'd0);
      check("rst_class",  64'(class_o), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // 1: fwd-only, fp_ret three cycles after fp_o, tie resolves to lane 2
      fp0 = fp_cnt; bp0 = bp_cnt; d0 = done_cnt;
      start = 1'b1; train = 1'b0;
      tick(); start = 1'b0;
      check("t1_fp_high", 64'(fp_o), 64'd1);
      check("t1_busy",    64'(busy), 64'd1);
      tick();
      check("t1_fp_low",  64'(fp_o), 64'd0);
      tick(); tick();
      fp_ret = 1'b1;
      a_in   = lanes(16'd5, 16'hFFFE, 16'd9, 16'd9);
      target = lanes(16'd3, 16'd4, 16'hFFFF, 16'd9);
      tick();
      fp_ret = 1'b0; a_in = '0; target = '0;
      check("t1_result",  64'(result), 64'(lanes(16'd5, 16'hFFFE, 16'd9, 16'd9)));
      check("t1_done_early", 64'(done), 64'd0);
      tick();
      check("t1_done",    64'(done),    64'd1);
      check("t1_class",   64'(class_o), 64'd2);
      check("t1_e",       64'(e_o),     64'(lanes(16'd2, 16'hFFFA, 16'd10, 16'd0)));
      tick();
      check("t1_idle",    64'(busy), 64'd0);
      check("t1_fp_cnt",  64'(fp_cnt - fp0),   64'd1);
      check("t1_bp_cnt",  64'(bp_cnt - bp0),   64'd0);
      check("t1_done_cnt", 64'(done_cnt - d0), 64'd1);

      // 2: training with saturation in both directions
      fp0 = fp_cnt; bp0 = bp_cnt; d0 = done_cnt;
      start = 1'b1; train = 1'b1;
      tick(); start = 1'b0; train = 1'b0;
      tick();
      fp_ret = 1'b1;
      a_in   = lanes(16'h7000, 16'h9000, 16'h7FFF, 16'h8000);
      target = lanes(16'h9000, 16'h7000, 16'h0001, 16'h0001);
      tick();
      fp_ret = 1'b0; a_in = '0; target = '0;
      tick();
      check("t2_bp_high", 64'(bp_o), 64'd1);
      check("t2_fp_low",  64'(fp_o), 64'd0);
      check("t2_e",       64'(e_o),  64'(lanes(16'h7FFF, 16'h8000, 16'h7FFE, 16'h8000)));
      check("t2_class",   64'(class_o), 64'd2);
      tick();
      check("t2_bp_low",  64'(bp_o), 64'd0);
      check("t2_wait",    64'(done), 64'd0);
      tick(); tick();
      check("t2_e_stable", 64'(e_o), 64'(lanes(16'h7FFF, 16'h8000, 16'h7FFE, 16'h8000)));
      bp_ret = 1'b1;
      tick();
      bp_ret = 1'b0;
      check("t2_done",    64'(done), 64'd1);
      check("t2_err",     64'(err),  64'd0);
      tick();
      check("t2_idle",    64'(busy), 64'd0);
      check("t2_fp_cnt",  64'(fp_cnt - fp0),   64'd1);
      check("t2_bp_cnt",  64'(bp_cnt - bp0),   64'd1);
      check("t2_done_cnt", 64'(done_cnt - d0), 64'd1);

      // 3: no fp_ret -> timeout; done on cycle 10 after start, outputs held
      bp0 = bp_cnt;
      start = 1'b1;
      tick(); start = 1'b0;
      c = 1;
      while (!done && c < 40) begin
         tick();
         c++;
      end
      check("t3_done_cycle", 64'(c),   64'd10);
      check("t3_err",        64'(err), 64'd1);
      check("t3_bp_cnt",     64'(bp_cnt - bp0), 64'd0);
      check("t3_result_held", 64'(result), 64'(lanes(16'h7000, 16'h9000, 16'h7FFF, 16'h8000)));
      check("t3_class_held", 64'(class_o), 64'd2);
      check("t3_e_held",     64'(e_o), 64'(lanes(16'h7FFF, 16'h8000, 16'h7FFE, 16'h8000)));
      tick();
      check("t3_err_sticky", 64'(err), 64'd1);

      // 4: fp_ret on the timeout cycle; start held high throughout, one step only
      fp0 = fp_cnt;
      start = 1'b1; train = 1'b0;
      tick();
      check("t4_err_cleared", 64'(err), 64'd0);
      repeat (7) tick();
      check("t4_still_busy", 64'(busy), 64'd1);
      tick();
      fp_ret = 1'b1;
      a_in   = lanes(16'hFFFB, 16'hFFFD, 16'hFFFD, 16'hFFF9);
      target = '0;
      tick();
      fp_ret = 1'b0; a_in = '0;
      check("t4_err_after_ret", 64'(err), 64'd0);
      check("t4_result", 64'(result), 64'(lanes(16'hFFFB, 16'hFFFD, 16'hFFFD, 16'hFFF9)));
      tick();
      check("t4_done",  64'(done),    64'd1);
      check("t4_class", 64'(class_o), 64'd1);
      check("t4_e",     64'(e_o), 64'(lanes(16'hFFFB, 16'hFFFD, 16'hFFFD, 16'hFFF9)));
      tick();
      check("t4_start_in_done_ignored", 64'(busy), 64'd0);
      start = 1'b0;
      tick();
      check("t4_idle",   64'(busy), 64'd0);
      check("t4_fp_cnt", 64'(fp_cnt - fp0), 64'd1);

      // 5: reset asserted in BWAIT, stray bp_ret afterwards, then a clean step
      start = 1'b1; train = 1'b1;
      tick(); start = 1'b0; train = 1'b0;
      tick();
      fp_ret = 1'b1;
      a_in   = lanes(16'd1, 16'd2, 16'd3, 16'd4);
      target = '0;
      tick();
      fp_ret = 1'b0; a_in = '0;
      tick(); tick(); tick();
      check("t5_pre_e",     64'(e_o),     64'(lanes(16'd1, 16'd2, 16'd3, 16'd4)));
      check("t5_pre_class", 64'(class_o), 64'd3);
      d0 = done_cnt;
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_busy",   64'(busy),    64'd0);
      check("t5_rst_e",      64'(e_o),     64'd0);
      check("t5_rst_result", 64'(result),  64'd0);
      check("t5_rst_class",  64'(class_o), 64'd0);
      check("t5_rst_bp",     64'(bp_o),    64'd0);
      @(negedge clk); @(negedge clk);
      rst_n  = 1'b1;
      bp_ret = 1'b1;
      tick(); tick();
      bp_ret = 1'b0;
      check("t5_stray_bp_busy", 64'(busy), 64'd0);
      check("t5_stray_bp_done", 64'(done_cnt - d0), 64'd0);
      start = 1'b1;
      tick(); start = 1'b0;
      check("t5_next_fp", 64'(fp_o), 64'd1);
      tick();
      fp_ret = 1'b1;
      a_in   = lanes(16'h0010, 16'h0020, 16'hFFFF, 16'h0030);
      target = lanes(16'h0010, 16'h0000, 16'h0000, 16'h0040);
      tick();
      fp_ret = 1'b0; a_in = '0; target = '0;
      tick();
      check("t5_done",  64'(done),    64'd1);
      check("t5_class", 64'(class_o), 64'd3);
      check("t5_e",     64'(e_o), 64'(lanes(16'h0000, 16'h0020, 16'hFFFF, 16'hFFF0)));
      tick();
      check("t5_idle",  64'(busy), 64'd0);
      check("fp_bp_overlap", 64'(both_cnt), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end
endmodule
